reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter DW, 32, data width in bits.
REQ-002 SHALL have parameter AW, 5, register address width; depth = 2**AW.
REQ-003 SHALL have parameter NRD, 2, number of read ports (1..4).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port Reset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port Rn  input  NRD*AW  read addresses; port i in bits [i*AW +: AW].
REQ-007 SHALL have port Q  output  NRD*DW  read data; port i in bits [i*DW +: DW].
REQ-008 SHALL have port Busy  output  NRD  pending-write flag for each read port's register.
REQ-009 SHALL have port We  input  1  write enable.
REQ-010 SHALL have port Wn  input  AW  write address.
REQ-011 SHALL have port Wd  input  DW  write data.
REQ-012 SHALL have port Se  input  1  set-busy enable (issue of a long-latency producer, e.g. load).
REQ-013 SHALL have port Sn  input  AW  set-busy address.
REQ-014 SHALL have port Clr  input  1  flush: clear all busy bits.
REQ-015 SHALL have port Err  output  1  registered one-cycle pulse on double-set of a busy register.

Function
REQ-016 SHALL write Wd into register Wn on the rising edge when We=1 and Wn!=0.
REQ-017 SHALL ignore writes to register 0; register 0 SHALL always read as 0.
REQ-018 SHALL drive Q[i] combinationally from register Rn[i]; zero-cycle read latency.
REQ-019 SHALL hold one busy bit per register; busy[0] SHALL be constant 0.
REQ-020 SHALL set busy[Sn] at the edge when Se=1 and Sn!=0.
REQ-021 SHALL clear busy[Wn] at the edge when We=1 and Wn!=0.
REQ-022 SHALL give set priority when Se and We target the same register in one cycle (busy stays 1, data still written).
REQ-023 SHALL clear all busy bits at the edge when Clr=1; Clr SHALL override Se and We busy effects in that cycle (data write still occurs).
REQ-024 SHALL drive Busy[i] combinationally as busy[Rn[i]]; Busy[i]=0 when Rn[i]=0.
REQ-025 SHALL pulse Err high for exactly the cycle after an edge where Se=1, Sn!=0, busy[Sn]=1, Clr=0, and not (We=1 and Wn=Sn).
REQ-026 SHALL treat multiple read ports addressing the same register independently and identically.

Reset
REQ-027 SHALL, while Reset=0, force all registers to 0, all busy bits to 0, Err to 0, asynchronously.
REQ-028 SHALL ignore We, Se, Clr while Reset=0; first update on first rising edge after Reset deasserts.
REQ-029 SHALL, on reset mid-operation, discard pending busy state; Q, Busy read 0 immediately.

Configuration
REQ-030 SHALL support macro REG_BYPASS_EN.
REQ-031 SHALL, with REG_BYPASS_EN defined, return Q[i]=Wd and Busy[i]=0 when We=1, Wn!=0, Wn=Rn[i] in the same cycle (write-to-read forwarding), unless Se=1 and Sn=Wn (Busy[i] then stays per REQ-024).
REQ-032 SHALL, without REG_BYPASS_EN, return the pre-write register value and pre-edge busy state in that cycle.

Structure
REQ-033 SHALL place default DW/AW/NRD constants and the data/address typedefs in shared package reg_pkg.
REQ-034 SHALL implement busy-bit logic and Err generation in sub-module reg_scoreboard (ports clk, Reset, Se, Sn, We, Wn, Clr, busy vector, Err).

Verification
REQ-035 Reset=0 then release; read Rn={1,2} -> Q={0,0}, Busy=0, Err=0.
REQ-036 We=1 Wn=1 Wd=0x12345678 one edge; Rn[0]=1 -> Q[0]=0x12345678; We=1 Wn=0 Wd=0xFFFFFFFF -> Rn=0 reads 0.
REQ-037 Same cycle We=1 Wn=3 Wd=0xA5A5A5A5, Rn[1]=3 -> with REG_BYPASS_EN Q[1]=0xA5A5A5A5 before edge; without, old value (0) before edge, 0xA5A5A5A5 after.
REQ-038 Se=1 Sn=5 -> Busy for Rn=5 is 1 next cycle; Se=1 Sn=5 again -> Err=1 for one cycle; We=1 Wn=5 -> Busy=0 after edge.
REQ-039 Se=1 Sn=7 and We=1 Wn=7 Wd=0x99 same cycle -> busy[7]=1, reg7=0x99; then Clr=1 with Se=1 Sn=8 -> all Busy=0, Err=0.
REQ-040 Reset=0 asserted mid-cycle with busy[5]=1, reg1=0x12345678 -> Busy, Q, Err go 0 without a clock edge.

Source files
------------

// File: rtl/reg_pkg.sv
// Shared constants and types for the scoreboarded register file.
// The default widths here are the ones the top-level parameters start from.
// Optional feature macro used by reg_file_sb: REG_BYPASS_EN (write-to-read forwarding).
package reg_pkg;

  localparam int DW_DEF  = 32;  // data width in bits
  localparam int AW_DEF  = 5;   // register address width, depth = 2**AW
  localparam int NRD_DEF = 2;   // number of read ports (1..4)

  typedef logic [DW_DEF-1:0] data_t;
  typedef logic [AW_DEF-1:0] addr_t;

endpackage : reg_pkg

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard for the register file.
// One busy bit per register marks a result still owed by a long-latency
// producer. Se marks it, a write of that register retires it, Clr flushes all.
// Err is a registered one-cycle pulse when an already-busy register is marked
// busy again without being retired in the same cycle.
module reg_scoreboard import reg_pkg::*; #(
  parameter int AW    = AW_DEF,
  parameter int DEPTH = 1 << AW
) (
  input  logic             clk,
  input  logic             Reset,   // asynchronous, active-low
  input  logic             Se,
  input  logic [AW-1:0]    Sn,
  input  logic             We,
  input  logic [AW-1:0]    Wn,
  input  logic             Clr,
  output logic [DEPTH-1:0] busy,
  output logic             Err
);

  logic [DEPTH-1:0] r_busy;
  logic             r_err;
  logic [DEPTH-1:0] w_busy_next;
  logic             w_err_next;
  logic             w_set;
  logic             w_clr;

  assign w_set = Se && (Sn != '0);
  assign w_clr = We && (Wn != '0);

  // Next busy vector: retire on write, then mark on set so set wins; flush overrides both.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    w_busy_next = r_busy;
    if (Clr) begin
      w_busy_next = '0;
    end else begin
      if (w_clr) w_busy_next[Wn] = 1'b0;
      if (w_set) w_busy_next[Sn] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  // Double-set detection: a set hitting a busy register that is not retired or flushed now.
  always_comb begin
    w_err_next = w_set && r_busy[Sn] && !Clr && !(We && (Wn == Sn));
  end

  // Busy and Err state; reset discards every pending producer.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      r_busy <= w_busy_next;
      r_err  <= w_err_next;
    end
  end

  assign busy = r_busy;
  assign Err  = r_err;

endmodule : reg_scoreboard

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with a busy-bit scoreboard.
// Register 0 is hard-wired to zero and is never busy. Reads are combinational.
// Optional macro REG_BYPASS_EN forwards same-cycle write data (and a cleared
// busy flag) to any read port addressing the register being written; without
// it, reads see the pre-edge contents.
module reg_file_sb import reg_pkg::*; #(
  parameter int DW  = DW_DEF,
  parameter int AW  = AW_DEF,
  parameter int NRD = NRD_DEF
) (
  input  logic              clk,
  input  logic              Reset,   // asynchronous, active-low
  input  logic [NRD*AW-1:0] Rn,
  output logic [NRD*DW-1:0] Q,
  output logic [NRD-1:0]    Busy,
  input  logic              We,
  input  logic [AW-1:0]     Wn,
  input  logic [DW-1:0]     Wd,
  input  logic              Se,
  input  logic [AW-1:0]     Sn,
  input  logic              Clr,
  output logic              Err
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    r_regs [DEPTH];
  logic [DEPTH-1:0] w_busy;
  logic             w_wr;

  assign w_wr = We && (Wn != '0);

  // Register storage; writes to register 0 are dropped so it always reads zero.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      // NOTE: the array is reset on purpose -- registers must read zero the moment reset asserts.
      for (int j = 0; j < DEPTH; j++) r_regs[j] <= '0;
    end else if (w_wr) begin
      r_regs[Wn] <= Wd;
    end
  end

  reg_scoreboard #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_scoreboard (
    .clk   (clk),
    .Reset (Reset),
    .Se    (Se),
    .Sn    (Sn),
    .We    (We),
    .Wn    (Wn),
    .Clr   (Clr),
    .busy  (w_busy),
    .Err   (Err)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic [DW-1:0] w_q;
    logic          w_busy_rd;

    assign w_ra = Rn[i*AW +: AW];

`ifdef REG_BYPASS_EN
    logic w_hit;
    logic w_keep_busy;

    // Forward only outside reset so an asserted reset still reads zero.
    assign w_hit       = Reset && w_wr && (Wn == w_ra);
    assign w_keep_busy = Se && (Sn == Wn);

    // Read port with write-to-read forwarding; a same-cycle re-mark keeps the old busy view.
    always_comb begin
      w_q       = w_hit ? Wd : r_regs[w_ra];
      w_busy_rd = (w_hit && !w_keep_busy) ? 1'b0 : w_busy[w_ra];
    end
`else
    // Plain read port: pre-edge register contents and busy state.
    always_comb begin
      w_q       = r_regs[w_ra];
      w_busy_rd = w_busy[w_ra];
    end
`endif

    assign Q[i*DW +: DW] = w_q;
    assign Busy[i]       = w_busy_rd;
  end

endmodule : reg_file_sb

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb (2 read ports, 32-bit data, 32 registers).
// Inputs change 1 ns after a rising edge; outputs are examined mid-cycle.
module tb_reg_file_sb;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;

  logic              clk;
  logic              Reset;
  logic [NRD*AW-1:0] Rn;
  logic [NRD*DW-1:0] Q;
  logic [NRD-1:0]    Busy;
  logic              We;
  logic [AW-1:0]     Wn;
  logic [DW-1:0]     Wd;
  logic              Se;
  logic [AW-1:0]     Sn;
  logic              Clr;
  logic              Err;

  int n_err;
  int n_chk;

  reg_file_sb #(.DW(DW), .AW(AW), .NRD(NRD)) dut (
    .clk   (clk),
    .Reset (Reset),
    .Rn    (Rn),
    .Q     (Q),
    .Busy  (Busy),
    .We    (We),
    .Wn    (Wn),
    .Wd    (Wd),
    .Se    (Se),
    .Sn    (Sn),
    .Clr   (Clr),
    .Err   (Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    We  = 1'b0;
    Se  = 1'b0;
    Clr = 1'b0;
    Wn  = '0;
    Sn  = '0;
    Wd  = '0;
  endtask

  task automatic set_rn(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    Rn = {a1, a0};
  endtask

  task automatic test_reset();
    idle();
    Reset = 1'b0;
    set_rn(5'd1, 5'd2);
    repeat (3) step();
    #3 Reset = 1'b1;
    step();
    n_chk++;
    if (Q !== 64'h0) begin
      n_err++; $display("FAIL reset_q: got %h expected %h", Q, 64'h0);
    end
    n_chk++;
    if (Busy !== 2'b00) begin
      n_err++; $display("FAIL reset_busy: got %b expected %b", Busy, 2'b00);
    end
    n_chk++;
    if (Err !== 1'b0) begin
      n_err++; $display("FAIL reset_err: got %b expected %b", Err, 1'b0);
    end
  endtask

  task automatic test_write_read();
    We = 1'b1; Wn = 5'd1; Wd = 32'h1234_5678;
    step();
    idle();
    set_rn(5'd1, 5'd0);
    #1;
    n_chk++;
    if (Q[31:0] !== 32'h1234_5678) begin
      n_err++; $display("FAIL write_r1: got %h expected %h", Q[31:0], 32'h1234_5678);
    end
    We = 1'b1; Wn = 5'd0; Wd = 32'hFFFF_FFFF;
    step();
    idle();
    set_rn(5'd0, 5'd0);
    #1;
    n_chk++;
    if (Q !== 64'h0) begin
      n_err++; $display("FAIL write_r0_ignored: got %h expected %h", Q, 64'h0);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] exp_pre;
`ifdef REG_BYPASS_EN
    exp_pre = 32'hA5A5_A5A5;
`else
    exp_pre = 32'h0;
`endif
    set_rn(5'd1, 5'd3);
    We = 1'b1; Wn = 5'd3; Wd = 32'hA5A5_A5A5;
    #1;
    n_chk++;
    if (Q[63:32] !== exp_pre) begin
      n_err++; $display("FAIL bypass_pre_edge: got %h expected %h", Q[63:32], exp_pre);
    end
    n_chk++;
    if (Q[31:0] !== 32'h1234_5678) begin
      n_err++; $display("FAIL bypass_other_port: got %h expected %h", Q[31:0], 32'h1234_5678);
    end
    step();
    idle();
    #1;
    n_chk++;
    if (Q[63:32] !== 32'hA5A5_A5A5) begin
      n_err++; $display("FAIL bypass_post_edge: got %h expected %h", Q[63:32], 32'hA5A5_A5A5);
    end
  endtask

  task automatic test_scoreboard();
    Se = 1'b1; Sn = 5'd5;
    step();
    idle();
    set_rn(5'd5, 5'd5);
    #1;
    n_chk++;
    if (Busy !== 2'b11) begin
      n_err++; $display("FAIL sb_set: got %b expected %b", Busy, 2'b11);
    end
    n_chk++;
    if (Err !== 1'b0) begin
      n_err++; $display("FAIL sb_first_set_err: got %b expected %b", Err, 1'b0);
    end
    Se = 1'b1; Sn = 5'd5;
    step();
    idle();
    n_chk++;
    if (Err !== 1'b1) begin
      n_err++; $display("FAIL sb_double_set_err: got %b expected %b", Err, 1'b1);
    end
    step();
    n_chk++;
    if (Err !== 1'b0) begin
      n_err++; $display("FAIL sb_err_one_cycle: got %b expected %b", Err, 1'b0);
    end
    // Re-mark and retire the same busy register in one cycle: no error, stays busy.
    Se = 1'b1; Sn = 5'd5; We = 1'b1; Wn = 5'd5; Wd = 32'h0000_0044;
    step();
    idle();
    n_chk++;
    if (Err !== 1'b0 || Busy !== 2'b11) begin
      n_err++; $display("FAIL sb_set_and_write: got err=%b busy=%b expected err=0 busy=11", Err, Busy);
    end
    We = 1'b1; Wn = 5'd5; Wd = 32'h0000_0055;
    step();
    idle();
    #1;
    n_chk++;
    if (Busy !== 2'b00) begin
      n_err++; $display("FAIL sb_write_clears: got %b expected %b", Busy, 2'b00);
    end
    n_chk++;
    if (Q[31:0] !== 32'h0000_0055) begin
      n_err++; $display("FAIL sb_write_data: got %h expected %h", Q[31:0], 32'h0000_0055);
    end
  endtask

  task automatic test_set_priority_and_flush();
    Se = 1'b1; Sn = 5'd7; We = 1'b1; Wn = 5'd7; Wd = 32'h0000_0099;
    step();
    idle();
    set_rn(5'd7, 5'd7);
    #1;
    n_chk++;
    if (Busy !== 2'b11) begin
      n_err++; $display("FAIL prio_busy: got %b expected %b", Busy, 2'b11);
    end
    n_chk++;
    if (Q !== {32'h0000_0099, 32'h0000_0099}) begin
      n_err++; $display("FAIL prio_data: got %h expected %h", Q, {32'h0000_0099, 32'h0000_0099});
    end
    // Mark r9 too, then flush while re-marking busy r7 and setting r8.
    Se = 1'b1; Sn = 5'd9;
    step();
    Clr = 1'b1; Se = 1'b1; Sn = 5'd7; We = 1'b1; Wn = 5'd2; Wd = 32'h0000_0022;
    step();
    idle();
    set_rn(5'd7, 5'd9);
    #1;
    n_chk++;
    if (Busy !== 2'b00 || Err !== 1'b0) begin
      n_err++; $display("FAIL flush_busy_err: got busy=%b err=%b expected busy=00 err=0", Busy, Err);
    end
    Clr = 1'b1; Se = 1'b1; Sn = 5'd8;
    step();
    idle();
    set_rn(5'd8, 5'd2);
    #1;
    n_chk++;
    if (Busy !== 2'b00 || Err !== 1'b0) begin
      n_err++; $display("FAIL flush_over_set: got busy=%b err=%b expected busy=00 err=0", Busy, Err);
    end
    n_chk++;
    if (Q[63:32] !== 32'h0000_0022) begin
      n_err++; $display("FAIL flush_write_kept: got %h expected %h", Q[63:32], 32'h0000_0022);
    end
  endtask

  task automatic test_mid_reset();
    Se = 1'b1; Sn = 5'd5;
    step();
    Se = 1'b1; Sn = 5'd5;
    step();
    idle();
    set_rn(5'd5, 5'd1);
    #1;
    n_chk++;
    if (Err !== 1'b1 || Busy[0] !== 1'b1 || Q[63:32] !== 32'h1234_5678) begin
      n_err++; $display("FAIL pre_reset_state: got err=%b busy0=%b q1=%h expected err=1 busy0=1 q1=12345678", Err, Busy[0], Q[63:32]);
    end
    #1 Reset = 1'b0;
    #1;
    n_chk++;
    if (Busy !== 2'b00 || Q !== 64'h0 || Err !== 1'b0) begin
      n_err++; $display("FAIL async_reset: got busy=%b q=%h err=%b expected all zero", Busy, Q, Err);
    end
    // Activity under reset must be ignored.
    We = 1'b1; Wn = 5'd1; Wd = 32'hDEAD_BEEF; Se = 1'b1; Sn = 5'd5;
    step();
    n_chk++;
    if (Busy !== 2'b00 || Q !== 64'h0 || Err !== 1'b0) begin
      n_err++; $display("FAIL reset_ignores_inputs: got busy=%b q=%h err=%b expected all zero", Busy, Q, Err);
    end
    idle();
    #2 Reset = 1'b1;
    step();
    n_chk++;
    if (Busy !== 2'b00 || Q !== 64'h0) begin
      n_err++; $display("FAIL post_reset: got busy=%b q=%h expected all zero", Busy, Q);
    end
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    Reset = 1'b0;
    Rn    = '0;
    idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_set_priority_and_flush();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_reg_file_sb
